iana_trace_buffer: RTL and testbench

- Synthesizable capture buffer for the per-cycle IANA trace vector produced by cpu_top.
- Stores trace entries in a DEPTH-deep FIFO.
- Drains entries as RD_W-bit beats, most-significant word first, so the software trace log keeps the "%08X %08X %08X %08X" order.
- Can stall the CPU when full (lossless mode) or drop entries and flag overflow (free-run mode).
- Keeps a free-running cycle counter for trace alignment.

---
 rtl/iana_trace_buffer.sv | 158 +++++++++++++++
 tb/tb_iana_trace_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iana_trace_buffer.sv
// rtl/iana_trace_buffer.sv - capture FIFO for the per-cycle IANA trace vector with beat-wise MSW-first readout
//
// Purpose:
//   Stores TRACE_W-bit trace entries in a DEPTH-deep FIFO and drains them as
//   RD_W-bit beats, most-significant word first. In stall mode a full FIFO
//   asks the CPU to freeze. Otherwise new entries are dropped and a sticky
//   overflow flag is raised. A free-running cycle counter supports
//   alignment with the software log.
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   trace_in             trace vector from cpu_top
//   trace_valid_in       trace_in is valid this cycle
//   stall_enable_in      sets the stall-mode flag
//   stall_disable_in     clears the stall-mode flag (wins over enable)
//   is_stall_enabled_out current stall-mode flag
//   cpu_stall_out        freeze request (stall flag & full, registers only)
//   clear_in             synchronous flush (highest priority)
//   rd_data_out          current beat (0 when empty)
//   rd_valid_out         a beat is available
//   rd_ready_in          consumer accepts the beat
//   rd_last_out          current beat is the last of its entry
//   count_out            number of stored entries
//   overflow_out         sticky: an entry was lost
//   cycle_count_out      cycles since reset or clear

module iana_trace_buffer #(
   parameter int TRACE_W = 128,
   parameter int RD_W    = 32,
   parameter int DEPTH   = 16,
   localparam int BEATS  = TRACE_W / RD_W,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TRACE_W-1:0] trace_in,
   input  logic               trace_valid_in,
   input  logic               stall_enable_in,
   input  logic               stall_disable_in,
   output logic               is_stall_enabled_out,
   output logic               cpu_stall_out,
   input  logic               clear_in,
   output logic [RD_W-1:0]    rd_data_out,
   output logic               rd_valid_out,
   input  logic               rd_ready_in,
   output logic               rd_last_out,
   output logic [CW-1:0]      count_out,
   output logic               overflow_out,
   output logic [31:0]        cycle_count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [TRACE_W-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          stall_q, stall_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   cycle_q, cycle_d;

   logic full, empty, rd_valid, rd_last, hs, pop, push, drop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign rd_valid = !empty;
   assign rd_last  = rd_valid && (beat_q == BW'(BEATS - 1));
   assign hs       = rd_valid && rd_ready_in;
   assign pop      = hs && rd_last;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push     = trace_valid_in && (!full || pop);
   assign drop     = trace_valid_in && full && !pop;

   // Beat 0 is the most significant word of the head entry.
   always_comb begin
      rd_data_out = '0;
      if (!empty) begin
         for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
               rd_data_out = mem_q[rd_ptr_q][TRACE_W-1-b*RD_W -: RD_W];
            end
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      beat_d   = beat_q;
      ovf_d    = ovf_q;
      cycle_d  = cycle_q + 32'd1;

      // Stall mode is independent of clear; disable wins over enable.
      stall_d = stall_q;
      if (stall_disable_in) begin
         stall_d = 1'b0;
      end else if (stall_enable_in) begin
         stall_d = 1'b1;
      end

      if (clear_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         beat_d   = '0;
         ovf_d    = 1'b0;
         cycle_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop) count_d = count_q + CW'(1);
         if (pop && !push) count_d = count_q - CW'(1);
         if (hs) beat_d = pop ? '0 : beat_q + BW'(1);
         if (drop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         beat_q   <= '0;
         stall_q  <= 1'b0;
         ovf_q    <= 1'b0;
         cycle_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         beat_q   <= beat_d;
         stall_q  <= stall_d;
         ovf_q    <= ovf_d;
         cycle_q  <= cycle_d;
      end
   end

   // Storage needs no reset: nothing is visible until count_q says so.
   always_ff @(posedge clk) begin
      if (push && !clear_in) begin
         mem_q[wr_ptr_q] <= trace_in;
      end
   end

   assign is_stall_enabled_out = stall_q;
   assign cpu_stall_out        = stall_q && full;
   assign rd_valid_out         = rd_valid;
   assign rd_last_out          = rd_last;
   assign count_out            = count_q;
   assign overflow_out         = ovf_q;
   assign cycle_count_out      = cycle_q;

endmodule

// File: tb/tb_iana_trace_buffer.sv
// tb/tb_iana_trace_buffer.sv - self-checking bench for iana_trace_buffer

module tb_iana_trace_buffer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] trace_in;
   logic         trace_valid_in;
   logic         stall_enable_in;
   logic         stall_disable_in;
   logic         is_stall_enabled_out;
   logic         cpu_stall_out;
   logic         clear_in;
   logic [31:0]  rd_data_out;
   logic         rd_valid_out;
   logic         rd_ready_in;
   logic         rd_last_out;
   logic [4:0]   count_out;
   logic         overflow_out;
   logic [31:0]  cycle_count_out;

   int checks   = 0;
   int failures = 0;

   iana_trace_buffer #(.TRACE_W(128), .RD_W(32), .DEPTH(16)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .trace_in             (trace_in),
      .trace_valid_in       (trace_valid_in),
      .stall_enable_in      (stall_enable_in),
      .stall_disable_in     (stall_disable_in),
      .is_stall_enabled_out (is_stall_enabled_out),
      .cpu_stall_out        (cpu_stall_out),
      .clear_in             (clear_in),
      .rd_data_out          (rd_data_out),
      .rd_valid_out         (rd_valid_out),
      .rd_ready_in          (rd_ready_in),
      .rd_last_out          (rd_last_out),
      .count_out            (count_out),
      .overflow_out         (overflow_out),
      .cycle_count_out      (cycle_count_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         tv;
      logic [127:0] td;
      logic         rdy;
      logic         en;
      logic         dis;
      logic         e_valid;
      logic [31:0]  e_data;
      logic         e_last;
      logic [4:0]   e_count;
      logic         e_flag;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mkv(logic tv, logic [127:0] td, logic rdy, logic en, logic dis,
                                logic ev, logic [31:0] ed, logic el, logic [4:0] ec, logic ef);
      vec_t v;
      v.tv = tv; v.td = td; v.rdy = rdy; v.en = en; v.dis = dis;
      v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_count = ec; v.e_flag = ef;
      return v;
   endfunction

   function automatic logic [127:0] mk(int k);
      logic [31:0] kk;
      kk = 32'(k);
      return {32'hE000_0000 | kk, 32'h0000_1000 + kk, 32'h0000_2000 + kk, 32'h0000_3000 + kk};
   endfunction

   function automatic logic [31:0] beat_of(logic [127:0] e, int b);
      return e[127-32*b -: 32];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic tv, logic [127:0] td, logic rdy, logic en, logic dis, logic clr);
      trace_valid_in   = tv;
      trace_in         = td;
      rd_ready_in      = rdy;
      stall_enable_in  = en;
      stall_disable_in = dis;
      clear_in         = clr;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reads entries first..last in order, checking every beat and its last flag.
   task automatic drain_check(string name, int first, int last);
      for (int k = first; k <= last; k++) begin
         for (int b = 0; b < 4; b++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk({name, "_data"}, rd_data_out, beat_of(mk(k), b));
            chk({name, "_last"}, 32'(rd_last_out), 32'(b == 3));
            tick();
         end
      end
      idle();
      #1;
      chk({name, "_empty"}, 32'(rd_valid_out), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ea, eb;
      ea = 128'h00000001_00000002_00000003_00000004;
      eb = 128'hA0000000_B0000000_C0000000_D0000000;

      tbl[0]  = mkv(1, ea, 1, 0, 0,  0, 32'h0,        0, 0, 0);
      tbl[1]  = mkv(1, eb, 1, 0, 0,  1, 32'h00000001, 0, 1, 0);
      tbl[2]  = mkv(0, '0, 1, 0, 0,  1, 32'h00000002, 0, 2, 0);
      tbl[3]  = mkv(0, '0, 1, 0, 0,  1, 32'h00000003, 0, 2, 0);
      tbl[4]  = mkv(0, '0, 1, 0, 0,  1, 32'h00000004, 1, 2, 0);
      tbl[5]  = mkv(0, '0, 1, 0, 0,  1, 32'hA0000000, 0, 1, 0);
      tbl[6]  = mkv(0, '0, 1, 0, 0,  1, 32'hB0000000, 0, 1, 0);
      tbl[7]  = mkv(0, '0, 1, 0, 0,  1, 32'hC0000000, 0, 1, 0);
      tbl[8]  = mkv(0, '0, 1, 0, 0,  1, 32'hD0000000, 1, 1, 0);
      tbl[9]  = mkv(0, '0, 1, 0, 0,  0, 32'h0,        0, 0, 0);
      tbl[10] = mkv(0, '0, 0, 1, 0,  0, 32'h0,        0, 0, 0);
      tbl[11] = mkv(0, '0, 0, 1, 1,  0, 32'h0,        0, 0, 1);
      tbl[12] = mkv(0, '0, 0, 0, 0,  0, 32'h0,        0, 0, 0);

      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", 32'(rd_valid_out), 32'd0);
      chk("rst_data", rd_data_out, 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_ovf", 32'(overflow_out), 32'd0);
      chk("rst_flag", 32'(is_stall_enabled_out), 32'd0);
      chk("rst_cycle", cycle_count_out, 32'd0);

      // Basic two-entry stream and stall-flag priority
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].tv, tbl[i].td, tbl[i].rdy, tbl[i].en, tbl[i].dis, 1'b0);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(rd_valid_out), 32'(tbl[i].e_valid));
         chk($sformatf("v%0d_data", i), rd_data_out, tbl[i].e_data);
         chk($sformatf("v%0d_last", i), 32'(rd_last_out), 32'(tbl[i].e_last));
         chk($sformatf("v%0d_count", i), 32'(count_out), 32'(tbl[i].e_count));
         chk($sformatf("v%0d_flag", i), 32'(is_stall_enabled_out), 32'(tbl[i].e_flag));
         chk($sformatf("v%0d_stall", i), 32'(cpu_stall_out), 32'd0);
         chk($sformatf("v%0d_ovf", i), 32'(overflow_out), 32'd0);
         tick();
      end
      idle();
      #1;
      chk("cycle_after_table", cycle_count_out, 32'd13);

      // Free-run overflow: 17 pushes, the 17th is lost
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, mk(k), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle();
      #1;
      chk("fr_count", 32'(count_out), 32'd16);
      chk("fr_ovf", 32'(overflow_out), 32'd1);
      chk("fr_stall", 32'(cpu_stall_out), 32'd0);
      drain_check("fr_drain", 1, 16);

      // Lossless mode: fill, stall, release by reading one entry
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, mk(k), 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         if (k == 16) chk("ll_stall_pre", 32'(cpu_stall_out), 32'd0);
         tick();
      end
      idle();
      #1;
      chk("ll_flag", 32'(is_stall_enabled_out), 32'd1);
      chk("ll_stall", 32'(cpu_stall_out), 32'd1);
      chk("ll_count", 32'(count_out), 32'd16);
      for (int b = 0; b < 4; b++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
         #1;
         chk("ll_beat", rd_data_out, beat_of(mk(1), b));
         chk("ll_stall_hold", 32'(cpu_stall_out), 32'd1);
         tick();
      end
      idle();
      #1;
      chk("ll_unstall", 32'(cpu_stall_out), 32'd0);
      chk("ll_count15", 32'(count_out), 32'd15);
      chk("ll_ovf", 32'(overflow_out), 32'd0);

      // Push and pop together at full
      drive(1'b1, mk(17), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      #1;
      chk("pp_refill", 32'(cpu_stall_out), 32'd1);
      for (int b = 0; b < 3; b++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, mk(18), 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("pp_last", 32'(rd_last_out), 32'd1);
      chk("pp_data", rd_data_out, beat_of(mk(2), 3));
      tick();
      idle();
      #1;
      chk("pp_count", 32'(count_out), 32'd16);
      chk("pp_ovf", 32'(overflow_out), 32'd0);
      chk("pp_stall", 32'(cpu_stall_out), 32'd1);

      // Disable stall while full
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      #1;
      chk("dis_stall", 32'(cpu_stall_out), 32'd0);
      chk("dis_flag", 32'(is_stall_enabled_out), 32'd0);
      chk("dis_count", 32'(count_out), 32'd16);
      drain_check("pp_drain", 3, 18);

      // Asynchronous reset in the middle of an entry
      drive(1'b1, mk(40), 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int b = 0; b < 2; b++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle();
      #1;
      chk("ar_pre_data", rd_data_out, beat_of(mk(40), 2));
      chk("ar_pre_flag", 32'(is_stall_enabled_out), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(rd_valid_out), 32'd0);
      chk("ar_data", rd_data_out, 32'd0);
      chk("ar_last", 32'(rd_last_out), 32'd0);
      chk("ar_count", 32'(count_out), 32'd0);
      chk("ar_flag", 32'(is_stall_enabled_out), 32'd0);
      chk("ar_stall", 32'(cpu_stall_out), 32'd0);
      chk("ar_cycle", cycle_count_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #1;
      chk("ar_cycle1", cycle_count_out, 32'd1);
      chk("ar_discard", 32'(rd_valid_out), 32'd0);

      // Clear with data, overflow and stall flag set
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 50; k < 67; k++) begin
         drive(1'b1, mk(k), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle();
      #1;
      chk("cl_pre_ovf", 32'(overflow_out), 32'd1);
      chk("cl_pre_count", 32'(count_out), 32'd16);
      chk("cl_pre_stall", 32'(cpu_stall_out), 32'd1);
      drive(1'b1, mk(99), 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      #1;
      chk("cl_count", 32'(count_out), 32'd0);
      chk("cl_ovf", 32'(overflow_out), 32'd0);
      chk("cl_cycle", cycle_count_out, 32'd0);
      chk("cl_flag", 32'(is_stall_enabled_out), 32'd1);
      chk("cl_valid", 32'(rd_valid_out), 32'd0);
      chk("cl_stall", 32'(cpu_stall_out), 32'd0);
      tick();
      #1;
      chk("cl_cycle1", cycle_count_out, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
